// File: rtl/io_access_ctrl_pkg.sv
// Shared definitions for the memory-mapped IO window: peripheral addresses,
// access-sequencer state encoding and the read value returned on a device timeout.
package io_defs;

   localparam logic [7:0]  IO_SW       = 8'h60;
   localparam logic [7:0]  IO_LED      = 8'h62;
   localparam logic [7:0]  IO_SEG      = 8'h70;
   localparam logic [3:0]  IO_DEV_BASE = 4'h8;

   localparam logic [1:0]  ST_IDLE_ENC     = 2'd0;
   localparam logic [1:0]  ST_WAIT_ACK_ENC = 2'd1;
   localparam logic [1:0]  ST_DONE_ENC     = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE     = ST_IDLE_ENC,
      ST_WAIT_ACK = ST_WAIT_ACK_ENC,
      ST_DONE     = ST_DONE_ENC
   } io_state_t;

   localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/io_access_ctrl_if.sv
// CPU-side IO bus: access strobes, address and store data from the core,
// load data and the stall back to it.
interface io_access_ctrl_if;

   logic        IORead;
   logic        IOWrite;
   logic [7:0]  io_addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;

   modport master (
      output IORead, IOWrite, io_addr, wdata,
      input  rdata, stall
   );

   modport slave (
      input  IORead, IOWrite, io_addr, wdata,
      output rdata, stall
   );

endinterface

// File: rtl/io_access_ctrl_decode.sv
// Low-address-byte decoder for the IO window; purely combinational so any
// IO block can share it.
module io_addr_decode
   import io_defs::*;
(
   input  logic [7:0] io_addr,
   output logic       is_sw,
   output logic       is_led,
   output logic       is_seg,
   output logic       is_dev,
   output logic       unmapped
);

   // Map the address byte onto exactly one peripheral select, or unmapped.
   always_comb begin
      is_sw    = (io_addr == IO_SW);
      is_led   = (io_addr == IO_LED);
      is_seg   = (io_addr == IO_SEG);
      is_dev   = (io_addr[7:4] == IO_DEV_BASE);
      unmapped = ~(is_sw | is_led | is_seg | is_dev);
   end

endmodule

// File: rtl/io_access_ctrl.sv
// Sequences CPU IO accesses: fast registers complete in one stall cycle,
// the slow device goes through a req/ack handshake bounded by TIMEOUT.
module io_access_ctrl
   import io_defs::*;
#(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
)(
   input  logic               clock,
   input  logic               reset,
   io_access_ctrl_if.slave    bus,
   input  logic [15:0]        switch_in,
   output logic [15:0]        led_out,
   output logic [31:0]        seg_out,
   output logic               dev_req,
   output logic               dev_we,
   output logic [3:0]         dev_addr,
   output logic [31:0]        dev_wdata,
   input  logic [31:0]        dev_rdata,
   input  logic               dev_ack,
   output logic               io_err
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   io_state_t   state_r;
   logic [15:0] cnt_r;
   logic [31:0] rdata_r;
   logic [15:0] led_r;
   logic [31:0] seg_r;
   logic        dev_req_r;
   logic        dev_we_r;
   logic [3:0]  dev_addr_r;
   logic [31:0] dev_wdata_r;
   logic        io_err_r;
   logic        stall_s;
   logic        req_s;
   logic        conflict_s;
   logic        is_sw_s, is_led_s, is_seg_s, is_dev_s, unmapped_s;

   io_addr_decode u_decode (
      .io_addr  (bus.io_addr),
      .is_sw    (is_sw_s),
      .is_led   (is_led_s),
      .is_seg   (is_seg_s),
      .is_dev   (is_dev_s),
      .unmapped (unmapped_s)
   );

   assign req_s      = bus.IORead | bus.IOWrite;
   assign conflict_s = bus.IORead & bus.IOWrite;

   // Stall the core from request acceptance until the DONE cycle; forced low in reset.
   always_comb begin
      stall_s = 1'b0;
      if (reset) begin
         stall_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE:     stall_s = req_s;
            ST_WAIT_ACK: stall_s = 1'b1;
            ST_DONE:     stall_s = 1'b0;
            default:     stall_s = 1'b0;
         endcase
      end
   end

   // Access FSM together with the peripheral registers and the ack timeout counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 16'd0;
         rdata_r     <= 32'd0;
         led_r       <= 16'd0;
         seg_r       <= 32'd0;
         dev_req_r   <= 1'b0;
         dev_we_r    <= 1'b0;
         dev_addr_r  <= 4'd0;
         dev_wdata_r <= 32'd0;
         io_err_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_s) begin
                  if (conflict_s || unmapped_s) begin
                     // Simultaneous read+write counts as unmapped: flag only, no side effects.
                     io_err_r <= 1'b1;
                     if (bus.IORead) rdata_r <= 32'd0;
                     state_r <= ST_DONE;
                  end else if (is_dev_s) begin
                     dev_req_r   <= 1'b1;
                     dev_we_r    <= bus.IOWrite;
                     dev_addr_r  <= bus.io_addr[3:0];
                     dev_wdata_r <= bus.wdata;
                     cnt_r       <= 16'd0;
                     state_r     <= ST_WAIT_ACK;
                  end else begin
                     if (bus.IOWrite) begin
                        if (is_led_s) led_r <= bus.wdata[15:0];
                        if (is_seg_s) seg_r <= bus.wdata;
                     end else begin
                        if (is_sw_s)       rdata_r <= {16'd0, switch_in};
                        else if (is_led_s) rdata_r <= {16'd0, led_r};
                        else               rdata_r <= seg_r;
                     end
                     state_r <= ST_DONE;
                  end
               end
            end
            ST_WAIT_ACK: begin
               // An ack in the timeout cycle takes priority and completes cleanly.
               if (dev_ack) begin
                  dev_req_r <= 1'b0;
                  dev_we_r  <= 1'b0;
                  if (!dev_we_r) rdata_r <= dev_rdata;
                  state_r <= ST_DONE;
               end else if (cnt_r == TO_LAST) begin
                  dev_req_r <= 1'b0;
                  dev_we_r  <= 1'b0;
                  if (!dev_we_r) rdata_r <= ERR_DATA;
                  io_err_r <= 1'b1;
                  state_r  <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_DONE: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign bus.rdata = rdata_r;
   assign bus.stall = stall_s;
   assign led_out   = led_r;
   assign seg_out   = seg_r;
   assign dev_req   = dev_req_r;
   assign dev_we    = dev_we_r;
   assign dev_addr  = dev_addr_r;
   assign dev_wdata = dev_wdata_r;
   assign io_err    = io_err_r;

endmodule

// File: tb/tb_io_access_ctrl.sv
// Directed plus randomized bench for io_access_ctrl, checked against a
// transaction-level model of the IO window.
module tb_io_access_ctrl;

   localparam int          TB_TIMEOUT = 8;
   localparam logic [31:0] TB_ERR     = 32'hDEAD_BEEF;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] switch_in = 16'd0;
   logic [15:0] led_out;
   logic [31:0] seg_out;
   logic        dev_req, dev_we;
   logic [3:0]  dev_addr;
   logic [31:0] dev_wdata;
   logic [31:0] dev_rdata = 32'd0;
   logic        dev_ack = 1'b0;
   logic        io_err;

   int errors = 0;
   int checks = 0;

   logic [15:0] m_led;
   logic [31:0] m_seg;
   logic [31:0] m_rdata;
   logic        m_err;

   io_access_ctrl_if bus();

   io_access_ctrl #(.TIMEOUT(TB_TIMEOUT), .ERR_DATA(TB_ERR)) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .switch_in(switch_in), .led_out(led_out), .seg_out(seg_out),
      .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .dev_rdata(dev_rdata), .dev_ack(dev_ack), .io_err(io_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_led = 16'd0; m_seg = 32'd0; m_rdata = 32'd0; m_err = 1'b0;
   endtask

   // Reference behaviour of one access, from the address map and timeout rules.
   task automatic model_xfer(input bit rd, input bit wr, input logic [7:0] addr,
                             input logic [31:0] wd, input int ack_at,
                             input logic [31:0] drd, output int exp_stalls);
      exp_stalls = 1;
      if (rd && wr) begin
         m_err = 1'b1; m_rdata = 32'd0;
      end else if (addr == 8'h60) begin
         if (rd) m_rdata = {16'd0, switch_in};
      end else if (addr == 8'h62) begin
         if (rd) m_rdata = {16'd0, m_led}; else m_led = wd[15:0];
      end else if (addr == 8'h70) begin
         if (rd) m_rdata = m_seg; else m_seg = wd;
      end else if (addr >= 8'h80 && addr <= 8'h8F) begin
         if (ack_at >= 1 && ack_at <= TB_TIMEOUT) begin
            exp_stalls = 1 + ack_at;
            if (rd) m_rdata = drd;
         end else begin
            exp_stalls = 1 + TB_TIMEOUT;
            if (rd) m_rdata = TB_ERR;
            m_err = 1'b1;
         end
      end else begin
         m_err = 1'b1;
         if (rd) m_rdata = 32'd0;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      bus.IORead = 1'b0; bus.IOWrite = 1'b0; dev_ack = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   // One CPU access; the bench acts as the slow device, acking in its ack_at-th request cycle.
   task automatic xfer(input string tag, input bit rd, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wd, input int ack_at, input logic [31:0] drd);
      int  stalls;
      int  req_cycles;
      int  exp_stalls;
      bit  req_ok;
      bit  done;
      stalls = 0; req_cycles = 0; req_ok = 1'b1; done = 1'b0;
      model_xfer(rd, wr, addr, wd, ack_at, drd, exp_stalls);
      @(negedge clock);
      bus.IORead = rd; bus.IOWrite = wr; bus.io_addr = addr; bus.wdata = wd;
      for (int i = 0; i < 400 && !done; i++) begin
         #1;
         if (!bus.stall) begin
            done = 1'b1;
         end else begin
            stalls++;
            dev_ack = 1'b0;
            if (dev_req) begin
               req_cycles++;
               if (dev_addr !== addr[3:0] || dev_we !== wr || dev_wdata !== wd) req_ok = 1'b0;
               dev_rdata = drd;
               dev_ack = (req_cycles == ack_at);
            end
            @(negedge clock);
            dev_ack = 1'b0;
         end
      end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_stalls"}, stalls, exp_stalls);
      if (req_cycles != 0) check({tag, "_devreq"}, {31'd0, req_ok}, 32'd1);
      check({tag, "_rdata"}, bus.rdata, m_rdata);
      check({tag, "_led"}, {16'd0, led_out}, {16'd0, m_led});
      check({tag, "_seg"}, seg_out, m_seg);
      check({tag, "_err"}, {31'd0, io_err}, {31'd0, m_err});
      check({tag, "_reqoff"}, {31'd0, dev_req}, 32'd0);
      bus.IORead = 1'b0; bus.IOWrite = 1'b0;
   endtask

   initial begin
      logic [7:0]  addr;
      logic [31:0] wd;
      logic [31:0] drd;
      int          ack_at;
      int          kind;
      bit          rd, wr;
      logic [31:0] held;

      bus.IORead = 1'b0; bus.IOWrite = 1'b0; bus.io_addr = 8'd0; bus.wdata = 32'd0;
      model_reset();
      #12;
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_led", {16'd0, led_out}, 32'd0);
      check("rst_seg", seg_out, 32'd0);
      check("rst_devreq", {31'd0, dev_req}, 32'd0);
      check("rst_err", {31'd0, io_err}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Reset arriving while the slow device request is outstanding.
      @(negedge clock);
      bus.IOWrite = 1'b1; bus.io_addr = 8'h84; bus.wdata = 32'h1357_9BDF;
      @(negedge clock);
      check("midrst_req_before", {31'd0, dev_req}, 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_req", {31'd0, dev_req}, 32'd0);
      check("midrst_stall", {31'd0, bus.stall}, 32'd0);
      check("midrst_we", {31'd0, dev_we}, 32'd0);
      check("midrst_wdata", dev_wdata, 32'd0);
      check("midrst_addr", {28'd0, dev_addr}, 32'd0);
      bus.IOWrite = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      model_reset();

      xfer("led_wr", 1'b0, 1'b1, 8'h62, 32'h0000_A5A5, 0, 32'd0);
      xfer("led_rd", 1'b1, 1'b0, 8'h62, 32'd0, 0, 32'd0);
      switch_in = 16'h1234;
      xfer("sw_rd", 1'b1, 1'b0, 8'h60, 32'd0, 0, 32'd0);
      xfer("seg_wr", 1'b0, 1'b1, 8'h70, 32'h89AB_CDEF, 0, 32'd0);
      xfer("seg_rd", 1'b1, 1'b0, 8'h70, 32'd0, 0, 32'd0);
      xfer("slow_rd", 1'b1, 1'b0, 8'h85, 32'd0, 5, 32'hCAFE_F00D);
      xfer("slow_wr", 1'b0, 1'b1, 8'h8A, 32'h0BAD_F00D, 3, 32'h5555_AAAA);

      // A stray ack while idle must not change anything.
      held = bus.rdata;
      @(negedge clock);
      dev_ack = 1'b1; dev_rdata = 32'h7777_7777;
      @(negedge clock);
      dev_ack = 1'b0;
      check("stray_ack", bus.rdata, held);

      xfer("tmo_rd", 1'b1, 1'b0, 8'h81, 32'd0, 0, 32'd0);
      do_reset();
      xfer("ack_at_limit", 1'b1, 1'b0, 8'h81, 32'd0, TB_TIMEOUT, 32'h2468_ACE0);

      xfer("pre_led", 1'b0, 1'b1, 8'h62, 32'h0000_1111, 0, 32'd0);
      xfer("unmapped_wr", 1'b0, 1'b1, 8'h40, 32'hFFFF_FFFF, 0, 32'd0);
      do_reset();
      xfer("both_strobes", 1'b1, 1'b1, 8'h62, 32'h0000_FFFF, 0, 32'd0);

      do_reset();
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 9);
         rd = $urandom_range(0, 1);
         wr = ~rd;
         if ($urandom_range(0, 19) == 0) begin rd = 1'b1; wr = 1'b1; end
         case (kind)
            0, 1:    addr = 8'h62;
            2, 3:    addr = 8'h70;
            4:       addr = 8'h60;
            5, 6, 7: addr = {4'h8, 4'($urandom_range(0, 15))};
            default: addr = 8'($urandom_range(0, 255));
         endcase
         if (addr == 8'h60 && wr && !rd) rd = 1'b1;
         if (addr == 8'h60 && rd) wr = ($urandom_range(0, 19) == 0);
         wd        = $urandom;
         drd       = $urandom;
         switch_in = 16'($urandom);
         ack_at    = $urandom_range(0, TB_TIMEOUT + 2);
         xfer("rand", rd, wr, addr, wd, ack_at, drd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
